// File: rtl/sparse_row_accumulator_if.sv
// sparse_row_accumulator_if: nonzero input lanes, vector read port and result stream; slave = accumulator view, master = environment view
interface sparse_row_accumulator_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_W = 32,
  parameter int COL_W = 10,
  parameter int ROW_W = 8
);
  logic [NUM_CHANNELS-1:0] in_valid;
  logic in_ready;
  logic [NUM_CHANNELS-1:0][DATA_W-1:0] in_value;
  logic [NUM_CHANNELS-1:0][COL_W-1:0] in_col;
  logic [NUM_CHANNELS-1:0][ROW_W-1:0] in_row;
  logic [NUM_CHANNELS-1:0] in_last;
  logic [NUM_CHANNELS-1:0][COL_W-1:0] vec_addr;
  logic [NUM_CHANNELS-1:0][DATA_W-1:0] vec_data;
  logic out_valid;
  logic out_ready;
  logic [ROW_W-1:0] out_row;
  logic [DATA_W-1:0] out_data;
  logic out_last;
  modport master (
    output in_valid, in_value, in_col, in_row, in_last, vec_data, out_ready,
    input in_ready, vec_addr, out_valid, out_row, out_data, out_last
  );
  modport slave (
    input in_valid, in_value, in_col, in_row, in_last, vec_data, out_ready,
    output in_ready, vec_addr, out_valid, out_row, out_data, out_last
  );
endinterface

// File: rtl/sparse_row_accumulator.sv
// sparse_row_accumulator: multi-lane SpMV multiply-accumulate into row sums, then streamed readout; ports clk/rst/start, busy/done, bus (lanes, vector port, result stream)
module sparse_row_accumulator #(
  parameter int NUM_CHANNELS = 4,
  parameter int MATRIX_SIZE = 128,
  parameter int DATA_W = 32,
  parameter int COL_W = 10,
  parameter int ROW_W = $clog2(MATRIX_SIZE) + 1,
  parameter int VEC_LAT = 1
) (
  input logic clk,
  input logic rst,
  input logic start,
  output logic busy,
  output logic done,
  sparse_row_accumulator_if.slave bus
);
  localparam int IW = $clog2(MATRIX_SIZE);
  localparam int CW = $clog2(VEC_LAT + 3);
  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, READOUT, DONE} state_t;
  state_t state, state_nxt;
  logic [NUM_CHANNELS-1:0] finished, accept, live;
  logic [NUM_CHANNELS-1:0] d_vld [VEC_LAT];
  logic [NUM_CHANNELS-1:0][DATA_W-1:0] d_val [VEC_LAT];
  logic [NUM_CHANNELS-1:0][ROW_W-1:0] d_row [VEC_LAT];
  logic [NUM_CHANNELS-1:0] p_vld;
  logic [NUM_CHANNELS-1:0][DATA_W-1:0] p_prod;
  logic [NUM_CHANNELS-1:0][ROW_W-1:0] p_row;
  logic [DATA_W-1:0] acc [MATRIX_SIZE];
  logic [DATA_W-1:0] acc_nxt [MATRIX_SIZE];
  logic [CW-1:0] cnt;
  logic [ROW_W-1:0] nxt_row;
  logic clr, all_fin, drain_done, hs;

  assign clr = start && (state == IDLE || state == DONE);
  assign accept = bus.in_valid & ~finished & {NUM_CHANNELS{state == ACCUM}};
  assign all_fin = &(finished | (accept & bus.in_last));
  assign drain_done = cnt == CW'(VEC_LAT + 1);
  assign hs = bus.out_valid && bus.out_ready;
  assign nxt_row = bus.out_row + 1'b1;
  assign bus.in_ready = state == ACCUM;
  assign bus.vec_addr = bus.in_col;
  assign busy = state == ACCUM || state == DRAIN || state == READOUT;
  assign done = state == DONE;

  // padding rows are accepted for in_last bookkeeping but never enter the pipeline
  always_comb begin
    live = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) live[k] = accept[k] && bus.in_row[k] < ROW_W'(MATRIX_SIZE);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? ACCUM : state;
      ACCUM: state_nxt = all_fin ? DRAIN : ACCUM;
      DRAIN: state_nxt = drain_done ? READOUT : DRAIN;
      READOUT: state_nxt = hs && bus.out_last ? DONE : READOUT;
      default: state_nxt = IDLE;
    endcase
  end

  // value/row ride alongside the external read so the product forms when vec_data lands
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < VEC_LAT; i++) begin
        d_vld[i] <= '0;
        d_val[i] <= '0;
        d_row[i] <= '0;
      end
      p_vld <= '0;
      p_prod <= '0;
      p_row <= '0;
    end else begin
      d_vld[0] <= live;
      d_val[0] <= bus.in_value;
      d_row[0] <= bus.in_row;
      for (int i = 1; i < VEC_LAT; i++) begin
        d_vld[i] <= d_vld[i-1];
        d_val[i] <= d_val[i-1];
        d_row[i] <= d_row[i-1];
      end
      p_vld <= d_vld[VEC_LAT-1];
      p_row <= d_row[VEC_LAT-1];
      for (int k = 0; k < NUM_CHANNELS; k++) p_prod[k] <= d_val[VEC_LAT-1][k] * bus.vec_data[k];
    end

  // every lane hitting a row adds into it, so same-cycle collisions sum
  always_comb
    for (int r = 0; r < MATRIX_SIZE; r++) begin
      acc_nxt[r] = acc[r];
      for (int k = 0; k < NUM_CHANNELS; k++)
        if (p_vld[k] && p_row[k] == ROW_W'(r)) acc_nxt[r] = acc_nxt[r] + p_prod[k];
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) for (int r = 0; r < MATRIX_SIZE; r++) acc[r] <= '0;
    else for (int r = 0; r < MATRIX_SIZE; r++) acc[r] <= clr ? '0 : acc_nxt[r];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      finished <= '0;
      cnt <= '0;
      bus.out_valid <= 1'b0;
      bus.out_row <= '0;
      bus.out_data <= '0;
      bus.out_last <= 1'b0;
    end else begin
      finished <= clr ? '0 : finished | (accept & bus.in_last);
      cnt <= state == DRAIN ? cnt + 1'b1 : '0;
      if (state == DRAIN && drain_done) begin
        bus.out_valid <= 1'b1;
        bus.out_row <= '0;
        bus.out_data <= acc[0];
        bus.out_last <= 1'b0;
      end else if (hs) begin
        bus.out_valid <= !bus.out_last;
        bus.out_row <= bus.out_last ? '0 : nxt_row;
        bus.out_data <= bus.out_last ? '0 : acc[nxt_row[IW-1:0]];
        bus.out_last <= !bus.out_last && nxt_row == ROW_W'(MATRIX_SIZE - 1);
      end
    end
endmodule

// File: tb/tb_sparse_row_accumulator.sv
// tb_sparse_row_accumulator: randomized and directed checks of the row accumulator against a behavioural row-sum model
module tb_sparse_row_accumulator;
  localparam int NC = 4;
  localparam int MS = 128;
  localparam int DW = 32;
  localparam int CLW = 10;
  localparam int RW = 8;
  localparam int VL = 3;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  always #5 clk = ~clk;

  sparse_row_accumulator_if #(.NUM_CHANNELS(NC), .DATA_W(DW), .COL_W(CLW), .ROW_W(RW)) bus ();
  sparse_row_accumulator #(.NUM_CHANNELS(NC), .MATRIX_SIZE(MS), .DATA_W(DW), .COL_W(CLW), .ROW_W(RW), .VEC_LAT(VL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus.slave)
  );

  logic [DW-1:0] vmem [1024];
  logic [NC-1:0][DW-1:0] dq [VL];
  always @(posedge clk) begin
    for (int k = 0; k < NC; k++) dq[0][k] <= vmem[bus.vec_addr[k]];
    for (int i = 1; i < VL; i++) dq[i] <= dq[i-1];
  end
  assign bus.vec_data = dq[VL-1];

  int n_cmp = 0, n_bad = 0, cyc = 0, exp_row = 0, rows_seen = 0, last_hs_cyc = -1;
  logic [DW-1:0] exp_acc [MS];
  logic [DW-1:0] got [MS];
  logic [NC-1:0] tb_fin;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk)
    if (rst === 1'b0) begin
      chk("busy_done_excl", 64'(busy & done), 64'd0);
      if (bus.out_valid) begin
        if (exp_row >= MS) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_row: got row %0d, want no more rows", bus.out_row);
        end else begin
          chk("out_row", 64'(bus.out_row), 64'(exp_row));
          chk("out_data", 64'(bus.out_data), 64'(exp_acc[exp_row]));
          chk("out_last", 64'(bus.out_last), 64'(exp_row == MS - 1));
          if (bus.out_ready) begin
            got[exp_row] = bus.out_data;
            rows_seen++;
            if (exp_row == MS - 1) last_hs_cyc = cyc;
            exp_row++;
          end
        end
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.in_valid = '0;
    bus.in_value = '0;
    bus.in_col = '0;
    bus.in_row = '0;
    bus.in_last = '0;
  endtask

  task automatic beat(input int k, input logic [DW-1:0] v, input logic [CLW-1:0] c, input logic [RW-1:0] r, input logic l);
    bus.in_valid[k] = 1'b1;
    bus.in_value[k] = v;
    bus.in_col[k] = c;
    bus.in_row[k] = r;
    bus.in_last[k] = l;
    if (!tb_fin[k]) begin
      if (r < MS) exp_acc[r] = exp_acc[r] + v * vmem[c];
      tb_fin[k] = l;
    end
  endtask

  function automatic logic [RW-1:0] rand_row();
    int p = int'($urandom % 10);
    return p < 2 ? RW'(MS + $urandom % MS) : p < 6 ? RW'($urandom % 8) : RW'($urandom % MS);
  endfunction

  task automatic begin_run();
    start = 1'b1;
    tb_fin = '0;
    step();
    start = 1'b0;
    for (int r = 0; r < MS; r++) exp_acc[r] = '0;
    exp_row = 0;
    rows_seen = 0;
    last_hs_cyc = -1;
    chk("accum_ready", 64'(bus.in_ready), 64'd1);
    chk("accum_busy", 64'(busy), 64'd1);
    chk("accum_done", 64'(done), 64'd0);
  endtask

  task automatic finish_run(input bit pattern);
    int i;
    clear_inputs();
    chk("drain_ready", 64'(bus.in_ready), 64'd0);
    chk("drain_busy", 64'(busy), 64'd1);
    repeat (VL + 1) step();
    chk("pre_readout_valid", 64'(bus.out_valid), 64'd0);
    step();
    chk("first_readout_valid", 64'(bus.out_valid), 64'd1);
    chk("first_readout_row", 64'(bus.out_row), 64'd0);
    for (i = 0; i < 4000 && !done; i++) begin
      bus.out_ready = pattern ? (i % 4 == 0 || i % 4 == 3) : ($urandom % 3 != 0);
      step();
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL readout_timeout: done never rose after %0d cycles", i);
    end
    chk("rows_seen", 64'(rows_seen), 64'(MS));
    chk("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
    chk("done_not_busy", 64'(busy), 64'd0);
    bus.out_ready = 1'b1;
  endtask

  task automatic run_random(input int len, input bit pattern, input bit poke);
    int left [NC];
    int c = 0;
    begin_run();
    for (int k = 0; k < NC; k++) left[k] = 1 + int'($urandom % len);
    while (tb_fin != '1 && c < 2000) begin
      clear_inputs();
      for (int k = 0; k < NC; k++)
        if (tb_fin[k] ? ($urandom % 3 == 0) : ($urandom % 4 != 0 || c > 4 * len)) begin
          if (!tb_fin[k]) left[k]--;
          beat(k, $urandom, CLW'($urandom), rand_row(), left[k] <= 0);
        end
      start = poke && c == 2;
      step();
      c++;
    end
    start = 1'b0;
    finish_run(pattern);
  endtask

  initial begin
    int f [NC];
    for (int i = 0; i < 1024; i++) vmem[i] = $urandom;
    rst = 1'b1;
    start = 1'b0;
    clear_inputs();
    bus.out_ready = 1'b0;
    bus.in_col[1] = 10'h2A5;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_row", 64'(bus.out_row), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("vec_addr_follows_col", 64'(bus.vec_addr[1]), 64'h2A5);
    rst = 1'b0;
    clear_inputs();
    step();
    bus.out_ready = 1'b1;

    vmem[5] = 7;
    begin_run();
    beat(0, 3, 5, 2, 1);
    beat(1, 0, 0, 200, 1);
    beat(2, 0, 0, 130, 1);
    beat(3, 0, 0, 128, 1);
    chk("model_single", 64'(exp_acc[2]), 64'd21);
    step();
    finish_run(0);
    chk("single_row2", 64'(got[2]), 64'd21);
    chk("single_row0", 64'(got[0]), 64'd0);
    chk("single_row127", 64'(got[127]), 64'd0);

    for (int k = 0; k < NC; k++) vmem[10+k] = 1;
    begin_run();
    for (int k = 0; k < NC; k++) beat(k, DW'(k + 1), CLW'(10 + k), 9, 1);
    chk("model_collision", 64'(exp_acc[9]), 64'd10);
    step();
    finish_run(1);
    chk("collision_row9", 64'(got[9]), 64'd10);

    vmem[30] = 1;
    vmem[31] = 3;
    begin_run();
    beat(0, 32'h7FFFFFFF, 30, 40, 1);
    beat(1, 1, 30, 40, 1);
    beat(2, 32'hFFFFFFFE, 31, 41, 1);
    beat(3, 0, 0, 255, 1);
    chk("model_wrap", 64'(exp_acc[40]), 64'h80000000);
    step();
    finish_run(0);
    chk("wrap_row40", 64'(got[40]), 64'h80000000);
    chk("sign_row41", 64'(got[41]), 64'hFFFFFFFA);

    vmem[1] = 1;
    f[0] = 3; f[1] = 8; f[2] = 8; f[3] = 20;
    begin_run();
    for (int c = 0; c <= 20; c++) begin
      clear_inputs();
      for (int k = 0; k < NC; k++) beat(k, c > f[k] ? 32'd100 : 32'd1, 1, RW'(20 + k), c == f[k]);
      if (c == 20) chk("stagger_ready_c20", 64'(bus.in_ready), 64'd1);
      step();
    end
    finish_run(0);
    chk("stagger_row20", 64'(got[20]), 64'd4);
    chk("stagger_row21", 64'(got[21]), 64'd9);
    chk("stagger_row22", 64'(got[22]), 64'd9);
    chk("stagger_row23", 64'(got[23]), 64'd21);

    run_random(12, 1, 0);
    run_random(20, 0, 1);
    run_random(6, 0, 0);

    begin_run();
    repeat (5) begin
      clear_inputs();
      for (int k = 0; k < NC; k++) beat(k, $urandom, CLW'($urandom), RW'($urandom % 8), 0);
      step();
    end
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    run_random(8, 0, 0);
    run_random(10, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
